// File: rtl/poly_tone_sequencer.sv
// poly_tone_sequencer: step-memory driven multi-channel square-wave tone sequencer
//
// Optional feature macro: TONE_GAP_EN
//   defined   -> each step is followed by a one-millisecond silent GAP state
//   undefined -> PLAY goes straight to LOAD of the next step
//
// Parameters: CHANNELS (1..4) tone channels, DEPTH (power of two, 2..64) step entries,
//             PRESCALE (>=1) clock cycles per pitch-unit strobe
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   ticks_per_milli  clock cycles per millisecond (0 behaves as 1)
//   wr_en/addr/data  step-memory write port; word = {hp[CHANNELS-1], ..., hp[0], duration_ms[7:0]}
//   start/stop/loop  begin play, abort play, restart from step 0 at the end marker
//   sound_ch         per-channel square waves
//   sound            one channel per cycle, selected round-robin by a free-running counter
//   led              {busy, 0, step index}
//   busy, done       play in progress, one-cycle pulse at normal song end
module poly_tone_sequencer #(
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 16,
    parameter int PRESCALE = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [15:0]                ticks_per_milli,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [8+10*CHANNELS-1:0]   wr_data,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop,
    output logic [CHANNELS-1:0]        sound_ch,
    output logic                       sound,
    output logic [7:0]                 led,
    output logic                       busy,
    output logic                       done
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = 8 + 10*CHANNELS;
    localparam int KW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

`ifdef TONE_GAP_EN
    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
`endif

    state_t                    state_q, state_d;
    logic [AW-1:0]             idx_q, idx_d;
    logic [WW-1:0]             word_q, word_d;
    logic [15:0]               tick_q, tick_d;
    logic [7:0]                ms_q, ms_d;
    logic [PW-1:0]             pre_q, pre_d;
    logic [CHANNELS-1:0][9:0]  cnt_q, cnt_d;
    logic [CHANNELS-1:0]       snd_q, snd_d;
    logic                      done_q, done_d;
    logic [KW-1:0]             k_q, k_d;
    logic [WW-1:0]             mem [DEPTH];
    logic [WW-1:0]             rd;
    logic [15:0]               tick_max;
    logic                      ms_stb;
    logic                      pre_stb;

    // Combinational read: a write landing on the same edge is not yet visible in LOAD.
    assign rd       = mem[idx_q];
    assign tick_max = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
    assign ms_stb   = tick_q == tick_max;
    assign pre_stb  = pre_q == PW'(PRESCALE - 1);

    always_ff @(posedge clk)
        if (wr_en) mem[wr_addr] <= wr_data;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
            tick_q  <= '0;
            ms_q    <= '0;
            pre_q   <= '0;
            cnt_q   <= '0;
            snd_q   <= '0;
            done_q  <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            tick_q  <= tick_d;
            ms_q    <= ms_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            snd_q   <= snd_d;
            done_q  <= done_d;
            k_q     <= k_d;
        end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        tick_d  = tick_q;
        ms_d    = ms_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        snd_d   = snd_q;
        done_d  = 1'b0;
        k_d     = (k_q == KW'(CHANNELS - 1)) ? '0 : k_q + 1'b1;
        case (state_q)
            IDLE: if (start && !stop) begin
                idx_d   = '0;
                state_d = LOAD;
            end
            LOAD: if (rd[7:0] == 8'd0) begin
                // End marker: restart only if that actually moves the index, else finish.
                if (loop && idx_q != '0) idx_d = '0;
                else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                word_d  = rd;
                tick_d  = '0;
                ms_d    = '0;
                pre_d   = '0;
                cnt_d   = '0;
                snd_d   = '0;
                state_d = PLAY;
            end
            PLAY: begin
                tick_d = ms_stb ? '0 : tick_q + 16'd1;
                ms_d   = ms_stb ? ms_q + 8'd1 : ms_q;
                pre_d  = pre_stb ? '0 : pre_q + 1'b1;
                for (int c = 0; c < CHANNELS; c++)
                    if (pre_stb && word_q[8+10*c +: 10] != 10'd0) begin
                        if (cnt_q[c] == word_q[8+10*c +: 10] - 10'd1) begin
                            cnt_d[c] = '0;
                            snd_d[c] = ~snd_q[c];
                        end else cnt_d[c] = cnt_q[c] + 10'd1;
                    end
                if (ms_stb && ms_q == word_q[7:0] - 8'd1) begin
`ifdef TONE_GAP_EN
                    state_d = GAP;
`else
                    idx_d   = idx_q + 1'b1;
                    state_d = LOAD;
`endif
                end
            end
`ifdef TONE_GAP_EN
            GAP: begin
                // The tick counter restarted on the strobe that ended PLAY, so this is one full ms.
                tick_d = ms_stb ? '0 : tick_q + 16'd1;
                if (ms_stb) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = LOAD;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        if (stop && state_q != IDLE) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end
    end

    assign busy     = state_q != IDLE;
    assign sound_ch = (state_q == PLAY) ? snd_q : '0;
    assign sound    = sound_ch[k_q];
    assign done     = done_q;
    assign led      = {busy, 1'b0, 6'(idx_q)};
endmodule

// File: tb/tb_poly_tone_sequencer.sv
// tb_poly_tone_sequencer: randomized and directed checks of poly_tone_sequencer against a trace model
module tb_poly_tone_sequencer;
    localparam int CH = 2;
    localparam int DP = 4;
    localparam int PS = 2;
    localparam int WW = 8 + 10*CH;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [5:0] idx;
        logic [1:0] snd;
        logic       lp;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   tpm;
    logic          wr_en;
    logic [1:0]    wr_addr;
    logic [WW-1:0] wr_data;
    logic          start, stop, loop;
    logic [CH-1:0] sound_ch;
    logic          sound;
    logic [7:0]    led;
    logic          busy, done;

    int            n_tests = 0;
    int            n_fail = 0;
    int            ecyc = 0;
    logic [WW-1:0] mm [DP];
    ent_t          exp_q[$];
    logic          inj = 1'b0;
    logic [1:0]    inj_addr;
    logic [WW-1:0] inj_data;

    poly_tone_sequencer #(.CHANNELS(CH), .DEPTH(DP), .PRESCALE(PS)) dut (
        .clk(clk), .rst_n(rst_n), .ticks_per_milli(tpm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .loop(loop),
        .sound_ch(sound_ch), .sound(sound), .led(led), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the DUT's mix selector must equal this mod CHANNELS.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) ecyc <= 0;
        else ecyc <= ecyc + 1;

    function automatic ent_t mk(logic b, logic d, int idx, logic [1:0] s, logic l);
        ent_t e;
        e.busy = b;
        e.done = d;
        e.idx  = 6'(idx);
        e.snd  = s;
        e.lp   = l;
        return e;
    endfunction

    function automatic logic [WW-1:0] step(int dur, int hp0, int hp1);
        return {10'(hp1), 10'(hp0), 8'(dur)};
    endfunction

    // Expected per-cycle trace from the start edge: one LOAD cycle per step, dur*ms PLAY cycles
    // where channel c has toggled floor(floor(j/PS)/hp) times, optional one-ms gap, end marker -> done.
    function automatic void build(int nloops, int maxlen);
        int idx = 0;
        int lp = nloops;
        int te = (tpm == 16'd0) ? 1 : int'(tpm);
        exp_q.delete();
        while (exp_q.size() < maxlen) begin
            int dur;
            logic [1:0] s;
            dur = int'(mm[idx][7:0]);
            exp_q.push_back(mk(1'b1, 1'b0, idx, 2'b00, lp > 0));
            if (dur == 0) begin
                if (lp > 0 && idx != 0) begin
                    lp--;
                    idx = 0;
                    continue;
                end
                exp_q.push_back(mk(1'b0, 1'b1, idx, 2'b00, 1'b0));
                exp_q.push_back(mk(1'b0, 1'b0, idx, 2'b00, 1'b0));
                break;
            end
            for (int j = 0; j < dur*te; j++) begin
                for (int c = 0; c < CH; c++) begin
                    int hp = int'(mm[idx][8+10*c +: 10]);
                    s[c] = (hp != 0) && (((j / PS) / hp) % 2 == 1);
                end
                exp_q.push_back(mk(1'b1, 1'b0, idx, s, lp > 0));
            end
`ifdef TONE_GAP_EN
            for (int j = 0; j < te; j++) exp_q.push_back(mk(1'b1, 1'b0, idx, 2'b00, lp > 0));
`endif
            idx = (idx + 1) % DP;
        end
        while (exp_q.size() > maxlen) void'(exp_q.pop_back());
    endfunction

    task automatic wr(int a, logic [WW-1:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = 2'(a);
        wr_data = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
        mm[a] = d;
    endtask

    task automatic song(logic [WW-1:0] s0, logic [WW-1:0] s1, logic [WW-1:0] s2, logic [WW-1:0] s3);
        wr(0, s0);
        wr(1, s1);
        wr(2, s2);
        wr(3, s3);
    endtask

    task automatic kick();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic play(string name);
        for (int i = 0; i < exp_q.size(); i++) begin
            ent_t e = exp_q[i];
            logic [12:0] got, want;
            @(negedge clk);
            got  = {busy, done, led, sound_ch, sound};
            want = {e.busy, e.done, e.busy, 1'b0, e.idx, e.snd, e.snd[ecyc % 2]};
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s cyc%0d {busy,done,led,sound_ch,sound} got=%b want=%b", name, i, got, want);
            end
            loop = e.lp;
            if (inj && i == 0) begin
                wr_en = 1'b1;
                wr_addr = inj_addr;
                wr_data = inj_data;
            end else if (inj && i == 1) begin
                wr_en = 1'b0;
                inj = 1'b0;
            end
        end
    endtask

    task automatic halt();
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
    endtask

    task automatic test_reset();
        #23;
        n_tests++;
        if ({busy, done, led, sound_ch, sound} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_held outputs got=%b want=0", {busy, done, led, sound_ch, sound});
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if ({busy, done, led, sound_ch, sound} !== 13'd0) begin
                n_fail++;
                $display("FAIL reset_idle outputs got=%b want=0", {busy, done, led, sound_ch, sound});
            end
        end
    endtask

    task automatic test_basic();
        tpm = 16'd10;
        song(step(2, 3, 0), step(0, 0, 0), step(0, 0, 0), step(0, 0, 0));
        build(0, 1000);
        kick();
        play("basic");
    endtask

    task automatic test_rest_mix();
        tpm = 16'd2;
        song(step(3, 2, 0), step(0, 5, 5), step(1, 1, 1), step(1, 1, 1));
        build(0, 1000);
        kick();
        play("rest_mix");
    endtask

    task automatic test_random();
        repeat (6) begin
            int em = int'($urandom_range(1, 3));
            tpm = 16'($urandom_range(0, 4));
            for (int a = 0; a < DP; a++)
                wr(a, step(a == em ? 0 : int'($urandom_range(1, 3)),
                           int'($urandom_range(0, 4)), int'($urandom_range(0, 4))));
            build(int'($urandom_range(0, 1)), 400);
            kick();
            play("random");
            if (busy) halt();
        end
    endtask

    task automatic test_stop();
        int n;
        logic [5:0] li;
        tpm = 16'd4;
        song(step(3, 1, 2), step(1, 3, 0), step(0, 0, 0), step(1, 1, 1));
        build(0, 1000);
        n = int'($urandom_range(3, 10));
        while (exp_q.size() > n) void'(exp_q.pop_back());
        li = exp_q[n-1].idx;
        kick();
        play("stop_pre");
        stop = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if ({busy, done, led, sound_ch, sound} !== {4'b0000, li, 3'b000}) begin
                n_fail++;
                $display("FAIL stop_idle got=%b want=%b", {busy, done, led, sound_ch, sound}, {4'b0000, li, 3'b000});
            end
        end
        build(0, 1000);
        kick();
        play("stop_replay");
    endtask

    task automatic test_loop();
        tpm = 16'd3;
        song(step(1, 1, 2), step(1, 0, 1), step(0, 0, 0), step(2, 2, 2));
        build(3, 1000);
        kick();
        play("loop");
    endtask

    task automatic test_wrap();
        tpm = 16'd0;
        song(step(2, 1, 0), step(1, 0, 1), step(3, 2, 3), step(1, 1, 1));
        build(0, 40);
        kick();
        play("wrap");
        halt();
    endtask

    task automatic test_same_cycle_write();
        tpm = 16'd2;
        song(step(2, 1, 0), step(0, 0, 0), step(0, 0, 0), step(0, 0, 0));
        build(0, 1000);
        inj = 1'b1;
        inj_addr = 2'd0;
        inj_data = step(1, 0, 2);
        kick();
        play("rw_old");
        mm[0] = inj_data;
        build(0, 1000);
        kick();
        play("rw_new");
    endtask

    task automatic test_async_reset();
        int n = int'($urandom_range(4, 9));
        tpm = 16'd3;
        song(step(3, 1, 2), step(2, 2, 1), step(0, 0, 0), step(0, 0, 0));
        build(0, 1000);
        while (exp_q.size() > n) void'(exp_q.pop_back());
        kick();
        play("arst_pre");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, led, sound_ch, sound} !== 13'd0) begin
            n_fail++;
            $display("FAIL arst_now got=%b want=0", {busy, done, led, sound_ch, sound});
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({busy, done, led, sound_ch, sound} !== 13'd0) begin
            n_fail++;
            $display("FAIL arst_after got=%b want=0", {busy, done, led, sound_ch, sound});
        end
        build(0, 1000);
        kick();
        play("arst_replay");
    endtask

    initial begin
        tpm = 16'd1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start = 1'b0;
        stop = 1'b0;
        loop = 1'b0;
        test_reset();
        test_basic();
        test_rest_mix();
        test_stop();
        test_loop();
        test_wrap();
        test_same_cycle_write();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
